// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage LC-3b pipeline: memory handshake
// tracking, load-use interlock, branch flush and saturating perf counters.
module pipe_hazard_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             imem_resp,
    input  logic             dmem_resp,
    input  logic             dmem_read,
    input  logic             dmem_write,
    input  logic             branch_taken,
    input  logic             id_ex_mem_read,
    input  logic [2:0]       id_ex_dest,
    input  logic [2:0]       if_id_sr1,
    input  logic             if_id_sr1_used,
    input  logic [2:0]       if_id_sr2,
    input  logic             if_id_sr2_used,
    input  logic             counter_clear,
    output logic             imem_read,
    output logic             dmem_req_read,
    output logic             dmem_req_write,
    output logic             load_pc,
    output logic             load_if_id,
    output logic             load_id_ex,
    output logic             load_ex_mem,
    output logic             load_mem_wb,
    output logic             flush_if_id,
    output logic             bubble_id_ex,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic             imem_done_q, imem_done_d;
    logic             dmem_done_q, dmem_done_d;
    logic [CNT_W-1:0] stall_count_q, stall_count_d;
    logic [CNT_W-1:0] flush_count_q, flush_count_d;

    logic dmem_need, imem_ready, dmem_ready, advance, load_use;

    assign dmem_need  = dmem_read | dmem_write;
    assign imem_ready = imem_resp | imem_done_q;
    assign dmem_ready = !dmem_need | dmem_resp | dmem_done_q;
    assign advance    = imem_ready & dmem_ready;
    assign load_use   = id_ex_mem_read &
                        ((if_id_sr1_used & (id_ex_dest == if_id_sr1)) |
                         (if_id_sr2_used & (id_ex_dest == if_id_sr2)));

    // Outputs are forced low while reset is held, even though reset is async.
    always_comb begin
        imem_read      = 1'b0;
        dmem_req_read  = 1'b0;
        dmem_req_write = 1'b0;
        load_pc        = 1'b0;
        load_if_id     = 1'b0;
        load_id_ex     = 1'b0;
        load_ex_mem    = 1'b0;
        load_mem_wb    = 1'b0;
        flush_if_id    = 1'b0;
        bubble_id_ex   = 1'b0;
        stall_count    = '0;
        flush_count    = '0;
        if (!reset) begin
            imem_read      = !imem_done_q;
            dmem_req_read  = dmem_read & !dmem_done_q;
            dmem_req_write = dmem_write & !dmem_done_q;
            stall_count    = stall_count_q;
            flush_count    = flush_count_q;
            if (advance) begin
                load_id_ex  = 1'b1;
                load_ex_mem = 1'b1;
                load_mem_wb = 1'b1;
                if (branch_taken) begin
                    load_pc      = 1'b1;
                    load_if_id   = 1'b1;
                    flush_if_id  = 1'b1;
                    bubble_id_ex = 1'b1;
                end else if (load_use) begin
                    bubble_id_ex = 1'b1;
                end else begin
                    load_pc    = 1'b1;
                    load_if_id = 1'b1;
                end
            end
        end
    end

    always_comb begin
        imem_done_d   = 1'b0;
        dmem_done_d   = 1'b0;
        stall_count_d = stall_count_q;
        flush_count_d = flush_count_q;
        if (!advance) begin
            imem_done_d = imem_done_q | imem_resp;
            dmem_done_d = dmem_done_q | (dmem_need & dmem_resp);
            if (stall_count_q != CNT_MAX)
                stall_count_d = stall_count_q + 1'b1;
        end else if (branch_taken && flush_count_q != CNT_MAX) begin
            flush_count_d = flush_count_q + 1'b1;
        end
        if (counter_clear) begin
            stall_count_d = '0;
            flush_count_d = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            imem_done_q   <= 1'b0;
            dmem_done_q   <= 1'b0;
            stall_count_q <= '0;
            flush_count_q <= '0;
        end else begin
            imem_done_q   <= imem_done_d;
            dmem_done_q   <= dmem_done_d;
            stall_count_q <= stall_count_d;
            flush_count_q <= flush_count_d;
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed-vector bench for pipe_hazard_ctrl (instantiated with 4-bit counters
// so saturation is reachable in a few cycles).
module tb_pipe_hazard_ctrl;

    localparam int CNT_W = 4;

    logic clk = 1'b0;
    logic reset;
    logic imem_resp, dmem_resp, dmem_read, dmem_write, branch_taken;
    logic id_ex_mem_read, if_id_sr1_used, if_id_sr2_used, counter_clear;
    logic [2:0] id_ex_dest, if_id_sr1, if_id_sr2;
    logic imem_read, dmem_req_read, dmem_req_write;
    logic load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb;
    logic flush_if_id, bubble_id_ex;
    logic [CNT_W-1:0] stall_count, flush_count;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .imem_resp(imem_resp), .dmem_resp(dmem_resp),
        .dmem_read(dmem_read), .dmem_write(dmem_write),
        .branch_taken(branch_taken), .id_ex_mem_read(id_ex_mem_read),
        .id_ex_dest(id_ex_dest), .if_id_sr1(if_id_sr1),
        .if_id_sr1_used(if_id_sr1_used), .if_id_sr2(if_id_sr2),
        .if_id_sr2_used(if_id_sr2_used), .counter_clear(counter_clear),
        .imem_read(imem_read), .dmem_req_read(dmem_req_read),
        .dmem_req_write(dmem_req_write), .load_pc(load_pc),
        .load_if_id(load_if_id), .load_id_ex(load_id_ex),
        .load_ex_mem(load_ex_mem), .load_mem_wb(load_mem_wb),
        .flush_if_id(flush_if_id), .bubble_id_ex(bubble_id_ex),
        .stall_count(stall_count), .flush_count(flush_count)
    );

    typedef struct {
        logic       ir, dr, rd, wr, br, mr;
        logic [2:0] dest, sr1;
        logic       sr1u;
        logic [2:0] sr2;
        logic       sr2u;
        logic [2:0] req;   // {imem_read, dmem_req_read, dmem_req_write}
        logic [4:0] ld;    // {pc, if_id, id_ex, ex_mem, mem_wb}
        logic       fl, bb;
    } vec_t;

    vec_t vecs [13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end else begin
            $display("ok   %s value=%h", name, act);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        imem_resp = 0; dmem_resp = 0; dmem_read = 0; dmem_write = 0;
        branch_taken = 0; id_ex_mem_read = 0; id_ex_dest = 0;
        if_id_sr1 = 0; if_id_sr1_used = 0; if_id_sr2 = 0; if_id_sr2_used = 0;
        counter_clear = 0;
    endtask

    function automatic logic [4:0] loads();
        return {load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb};
    endfunction

    function automatic logic [2:0] reqs();
        return {imem_read, dmem_req_read, dmem_req_write};
    endfunction

    initial begin
        //           ir dr rd wr br mr dest sr1 u  sr2 u   req     ld        fl bb
        vecs[0]  = '{1, 0, 0, 0, 0, 0, 0,   0,  0, 0,  0, 3'b100, 5'b11111, 0, 0};
        vecs[1]  = '{0, 0, 0, 0, 0, 0, 0,   0,  0, 0,  0, 3'b100, 5'b00000, 0, 0};
        vecs[2]  = '{0, 1, 0, 0, 0, 0, 0,   0,  0, 0,  0, 3'b100, 5'b00000, 0, 0};
        vecs[3]  = '{1, 1, 1, 0, 0, 0, 0,   0,  0, 0,  0, 3'b110, 5'b11111, 0, 0};
        vecs[4]  = '{0, 0, 0, 1, 0, 0, 0,   0,  0, 0,  0, 3'b101, 5'b00000, 0, 0};
        vecs[5]  = '{1, 0, 0, 0, 0, 1, 3,   0,  0, 3,  1, 3'b100, 5'b00111, 0, 1};
        vecs[6]  = '{1, 0, 0, 0, 0, 1, 3,   0,  0, 3,  0, 3'b100, 5'b11111, 0, 0};
        vecs[7]  = '{1, 0, 0, 0, 0, 1, 5,   5,  1, 0,  0, 3'b100, 5'b00111, 0, 1};
        vecs[8]  = '{1, 0, 0, 0, 0, 1, 5,   5,  0, 4,  1, 3'b100, 5'b11111, 0, 0};
        vecs[9]  = '{1, 0, 0, 0, 0, 0, 5,   5,  1, 5,  1, 3'b100, 5'b11111, 0, 0};
        vecs[10] = '{1, 0, 0, 0, 1, 1, 3,   0,  0, 3,  1, 3'b100, 5'b11111, 1, 1};
        vecs[11] = '{1, 1, 0, 1, 1, 0, 0,   0,  0, 0,  0, 3'b101, 5'b11111, 1, 1};
        vecs[12] = '{1, 0, 0, 0, 0, 1, 0,   0,  1, 0,  0, 3'b100, 5'b00111, 0, 1};

        // Reset held with imem_resp=1: everything must read 0.
        idle_inputs();
        reset = 1; imem_resp = 1; dmem_read = 1;
        #2;
        check("rst_loads", 32'(loads()), 32'h0);
        check("rst_reqs", 32'(reqs()), 32'h0);
        check("rst_flush_bubble", {30'h0, flush_if_id, bubble_id_ex}, 32'h0);
        tick();
        check("rst_after_edge_loads", 32'(loads()), 32'h0);
        reset = 0; dmem_read = 0;
        #1;
        check("post_rst_reqs", 32'(reqs()), 32'h4);
        check("post_rst_loads", 32'(loads()), 32'h1f);
        check("post_rst_stall", 32'(stall_count), 32'h0);

        // Single-cycle vectors: none leave a done flag set behind.
        for (int i = 0; i < 13; i++) begin
            tick();
            imem_resp = vecs[i].ir; dmem_resp = vecs[i].dr;
            dmem_read = vecs[i].rd; dmem_write = vecs[i].wr;
            branch_taken = vecs[i].br; id_ex_mem_read = vecs[i].mr;
            id_ex_dest = vecs[i].dest; if_id_sr1 = vecs[i].sr1;
            if_id_sr1_used = vecs[i].sr1u; if_id_sr2 = vecs[i].sr2;
            if_id_sr2_used = vecs[i].sr2u;
            #1;
            check($sformatf("vec%0d_reqs", i), 32'(reqs()), 32'(vecs[i].req));
            check($sformatf("vec%0d_loads", i), 32'(loads()), 32'(vecs[i].ld));
            check($sformatf("vec%0d_fl_bb", i), {30'h0, flush_if_id, bubble_id_ex},
                  {30'h0, vecs[i].fl, vecs[i].bb});
        end
        tick();
        idle_inputs();
        imem_resp = 1;
        #1;
        check("table_stall_count", 32'(stall_count), 32'd3);
        check("table_flush_count", 32'(flush_count), 32'd2);

        // Clear wins; counters zero after the edge.
        counter_clear = 1;
        tick();
        counter_clear = 0;
        #1;
        check("clear_stall", 32'(stall_count), 32'd0);
        check("clear_flush", 32'(flush_count), 32'd0);

        // Data wait: imem returns on cycle 1, dmem on cycle 4.
        for (int c = 1; c <= 4; c++) begin
            tick();
            idle_inputs();
            dmem_read = 1;
            imem_resp = (c == 1);
            dmem_resp = (c == 4);
            #1;
            check($sformatf("dwait%0d_imem_read", c), 32'(imem_read), (c == 1) ? 32'd1 : 32'd0);
            check($sformatf("dwait%0d_dreq", c), 32'(dmem_req_read), 32'd1);
            check($sformatf("dwait%0d_loads", c), 32'(loads()), (c == 4) ? 32'h1f : 32'h0);
        end
        tick();
        idle_inputs();
        dmem_read = 1;
        #1;
        check("dwait_stall_count", 32'(stall_count), 32'd3);
        check("dwait_flags_clear", 32'(reqs()), 32'h6);

        // Saturation at 15 with 4-bit counters, then clear during a stall.
        counter_clear = 1;
        dmem_read = 0;
        tick();
        counter_clear = 0;
        for (int c = 0; c < 20; c++) tick();
        check("sat_stall_count", 32'(stall_count), 32'd15);
        counter_clear = 1;
        tick();
        counter_clear = 0;
        #1;
        check("sat_clear_stall", 32'(stall_count), 32'd0);

        // Async reset mid-cycle while dmem_done is set.
        dmem_read = 1; dmem_resp = 1;
        tick();
        dmem_resp = 0;
        #1;
        check("pre_arst_dreq", 32'(dmem_req_read), 32'd0);
        check("pre_arst_stall", 32'(stall_count), 32'd1);
        reset = 1;
        #1;
        check("arst_stall", 32'(stall_count), 32'd0);
        check("arst_reqs", 32'(reqs()), 32'h0);
        reset = 0; dmem_read = 0; dmem_write = 1;
        #1;
        check("arst_rel_reqs", 32'(reqs()), 32'h5);
        check("arst_rel_stall", 32'(stall_count), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage LC-3b pipeline.
- Generates the load enables for PC, if_id, id_ex, ex_mem and mem_wb, plus the flush/bubble controls.
- Holds instruction-memory and data-memory request handshakes open until both complete, and remembers a response that arrives while the other side is still pending.
- Detects load-use hazards, applies branch redirect flush, and keeps saturating stall/flush performance counters.

Parameters:
- CNT_W, 16, width of the stall_count and flush_count counters.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- imem_resp  in  1  instruction memory has returned the fetch word this cycle.
- dmem_resp  in  1  data memory access completes this cycle.
- dmem_read  in  1  MEM-stage instruction reads memory (ex_mem ctrl word).
- dmem_write  in  1  MEM-stage instruction writes memory (ex_mem ctrl word).
- branch_taken  in  1  MEM-stage PC redirect (pc_mux select nonzero).
- id_ex_mem_read  in  1  EX-stage instruction is a load (LDR/LDB/LDI).
- id_ex_dest  in  3  EX-stage destination register.
- if_id_sr1  in  3  ID-stage source 1.
- if_id_sr1_used  in  1  ID-stage instruction reads sr1.
- if_id_sr2  in  3  ID-stage source 2.
- if_id_sr2_used  in  1  ID-stage instruction reads sr2.
- counter_clear  in  1  synchronous clear of both counters.
- imem_read  out  1  fetch request.
- dmem_req_read  out  1  gated data read request.
- dmem_req_write  out  1  gated data write request.
- load_pc  out  1  PC register enable.
- load_if_id  out  1  if_id register enable.
- load_id_ex  out  1  id_ex register enable.
- load_ex_mem  out  1  ex_mem register enable.
- load_mem_wb  out  1  mem_wb register enable.
- flush_if_id  out  1  load if_id with a NOP.
- bubble_id_ex  out  1  load id_ex with zero control word and dest 0.
- stall_count  out  CNT_W  cycles the pipeline was frozen.
- flush_count  out  CNT_W  taken-branch flushes.

Behaviour:
- State registers: imem_done, dmem_done, stall_count, flush_count. Reset asynchronously clears all of them to 0.
- While reset is high, every output is 0.
- Combinational terms:
  - dmem_need = dmem_read | dmem_write.
  - imem_ready = imem_resp | imem_done.
  - dmem_ready = !dmem_need | dmem_resp | dmem_done.
  - advance = imem_ready & dmem_ready.
  - load_use = id_ex_mem_read & ((if_id_sr1_used & id_ex_dest==if_id_sr1) | (if_id_sr2_used & id_ex_dest==if_id_sr2)).
- Request outputs (zero-latency, combinational):
  - imem_read = !imem_done.
  - dmem_req_read = dmem_read & !dmem_done.
  - dmem_req_write = dmem_write & !dmem_done.
  - A completed side must not re-request while the other side is still pending.
- Stall (advance=0): all load_* = 0, flush_if_id = bubble_id_ex = 0.
  - Next-state: imem_done <= imem_done | imem_resp; dmem_done <= dmem_done | (dmem_need & dmem_resp).
- Advance with branch_taken=1:
  - All load_* = 1, flush_if_id = 1, bubble_id_ex = 1.
  - branch_taken has priority over load_use.
- Advance with load_use=1, branch_taken=0:
  - load_pc = load_if_id = 0; load_id_ex = load_ex_mem = load_mem_wb = 1; bubble_id_ex = 1.
  - Fetch is reissued next cycle.
- Advance, no hazard: all load_* = 1, no flush or bubble.
- On any advance: imem_done <= 0, dmem_done <= 0.
- Simultaneous imem_resp and dmem_resp in one cycle with both pending: advance that cycle; no flag is set.
- stall_count:
  - +1 on each cycle with advance=0.
  - Saturates at 2^CNT_W-1.
- flush_count:
  - +1 on each cycle with advance & branch_taken.
  - Saturates at 2^CNT_W-1.
- counter_clear = 1: both counters <= 0 next edge; clear wins over increment.
- Reset mid-stall: flags and counters clear immediately. After release, imem_read = 1 and any dmem request is reissued from scratch.
- Latency: all control outputs are combinational from inputs and flags in the same cycle. Flags and counters update on the rising clk edge.

Test Plan:
- Reset with imem_resp held 1 → all outputs 0 during reset. First cycle after release: imem_read=1, all load_*=1, stall_count=0.
- Data wait: dmem_read=1, dmem_resp=0 for 3 cycles, imem_resp=1 on the first of them, dmem_resp=1 on the 4th → load_*=0 for 3 cycles. imem_read=0 from cycle 2, dmem_req_read=1 throughout. Advance on cycle 4; stall_count=3; both flags 0 afterwards.
- Load-use: id_ex_mem_read=1, id_ex_dest=3, if_id_sr2=3, if_id_sr2_used=1, both memories ready → load_pc=load_if_id=0, load_id_ex=1, bubble_id_ex=1, load_ex_mem=load_mem_wb=1. The same case with sr2_used=0 → no bubble.
- Branch plus load-use in the same ready cycle → flush_if_id=1, bubble_id_ex=1, all load_*=1, flush_count 0→1.
- Saturation with CNT_W=4: 20 stall cycles → stall_count holds 15. Then counter_clear=1 together with a stall → stall_count=0.
- Async reset asserted mid-cycle while dmem_done=1 → flags and counters 0 immediately without a clock edge. After release with dmem_write=1 → dmem_req_write=1.
